// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-signed decoder.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    FINISH
  } state_t;

  // Largest legal decimal digit, and the digit value at which a
  // reverse double-dabble correction (subtract 3) is applied.
  localparam int unsigned BCD_DIGIT_MAX = 9;
  localparam int unsigned CORR_THRESH   = 8;

  // Number of bits needed to hold 0..10^digits-1, which is also the
  // number of shift/correct iterations.
  function automatic int unsigned calc_iter(input int unsigned digits);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return int'($clog2(p));
  endfunction

endpackage

// File: rtl/bcd_sub3.sv
// Per-digit correction for reverse double-dabble: subtract 3 from a
// BCD digit that is 8 or more after the right shift.
module bcd_sub3
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Conditional subtract-3
  always_comb begin
    dout = din;
    if (din >= 4'(CORR_THRESH)) begin
      dout = din - 4'd3;
    end
  end

endmodule

// File: rtl/bcd_to_signed.sv
// Sequential packed-BCD plus sign to two's-complement decoder. One
// shift-right and per-digit correction per clock (reverse double-dabble),
// then range check and saturation into an OUT_W-bit result.
module bcd_to_signed
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int OUT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic [4*DIGITS-1:0]   bcd_i,
  input  logic                  sign_i,
  output logic                  busy_o,
  output logic                  ready_o,
  output logic [OUT_W-1:0]      result_o,
  output logic                  overflow_o,
  output logic                  error_o
);

  localparam int unsigned ITER  = calc_iter(DIGITS);
  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + ITER;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  localparam logic [31:0]      POS_MAX = 32'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic [31:0]      NEG_MAX = 32'(64'd1 << (OUT_W - 1));
  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  state_t              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sign_q, sign_d;
  logic                err_q, err_d;
  logic [OUT_W-1:0]    result_q, result_d;
  logic                ovf_q, ovf_d;
  logic                errout_q, errout_d;
  logic                ready_q, ready_d;

  logic [SR_W-1:0]     shifted;
  logic [BCD_W-1:0]    corrected;
  logic                digit_err;
  logic [31:0]         mag32;
  logic [31:0]         neg32;

  assign shifted = sr_q >> 1;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_corr
      bcd_sub3 u_sub3 (
        .din  (shifted[ITER + 4*g +: 4]),
        .dout (corrected[4*g +: 4])
      );
    end
  endgenerate

  // Flag any incoming digit that is not a decimal digit
  always_comb begin
    digit_err = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_i[4*i +: 4] > 4'(BCD_DIGIT_MAX)) begin
        digit_err = 1'b1;
      end
    end
  end

  // Binary magnitude and its two's-complement negation, 32 bits wide
  always_comb begin
    mag32 = 32'(sr_q[ITER-1:0]);
    neg32 = 32'd0 - mag32;
  end

  // Next-state, datapath and output-register logic
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    err_d    = err_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    errout_d = errout_q;
    ready_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          sr_d    = {bcd_i, {ITER{1'b0}}};
          cnt_d   = '0;
          sign_d  = sign_i;
          err_d   = digit_err;
          state_d = digit_err ? FINISH : CONVERT;
        end
      end
      CONVERT: begin
        sr_d  = {corrected, shifted[ITER-1:0]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        ready_d  = 1'b1;
        errout_d = err_q;
        if (err_q) begin
          result_d = '0;
          ovf_d    = 1'b0;
        end else if (!sign_q) begin
          if (mag32 > POS_MAX) begin
            result_d = SAT_POS;
            ovf_d    = 1'b1;
          end else begin
            result_d = mag32[OUT_W-1:0];
            ovf_d    = 1'b0;
          end
        end else begin
          if (mag32 > NEG_MAX) begin
            result_d = SAT_NEG;
            ovf_d    = 1'b1;
          end else begin
            result_d = neg32[OUT_W-1:0];
            ovf_d    = 1'b0;
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      errout_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      err_q    <= err_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      errout_q <= errout_d;
      ready_q  <= ready_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign ready_o    = ready_q;
  assign result_o   = result_q;
  assign overflow_o = ovf_q;
  assign error_o    = errout_q;

endmodule

// File: tb/tb_bcd_to_signed.sv
// Self-checking bench for bcd_to_signed: directed cases plus randomized
// requests compared against a decimal-arithmetic reference model.
module tb_bcd_to_signed;

  logic        clk;
  logic        reset;
  logic        valid_i;
  logic [11:0] bcd_i;
  logic        sign_i;
  logic        busy_o;
  logic        ready_o;
  logic [7:0]  result_o;
  logic        overflow_o;
  logic        error_o;

  int checks   = 0;
  int failures = 0;

  bcd_to_signed #(.DIGITS(3), .OUT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (valid_i),
    .bcd_i      (bcd_i),
    .sign_i     (sign_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .result_o   (result_o),
    .overflow_o (overflow_o),
    .error_o    (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Decimal reference: value of the digits, then the signed range rules
  function automatic void ref_model(input logic [11:0] b, input logic s,
                                    output logic [7:0] r, output logic o,
                                    output logic e, output int lat);
    int m;
    m = 0;
    e = 1'b0;
    for (int d = 2; d >= 0; d--) begin
      int dig;
      dig = int'(b[4*d +: 4]);
      if (dig > 9) e = 1'b1;
      m = m * 10 + dig;
    end
    o = 1'b0;
    if (e) begin
      r   = 8'h00;
      lat = 1;
    end else begin
      lat = 11;
      if (!s) begin
        if (m > 127) begin r = 8'h7F; o = 1'b1; end
        else r = 8'(m);
      end else begin
        if (m > 128) begin r = 8'h80; o = 1'b1; end
        else r = 8'((256 - m) % 256);
      end
    end
  endfunction

  // Present a request; it is accepted at the next rising edge
  task automatic start(input logic [11:0] b, input logic s);
    valid_i = 1'b1;
    bcd_i   = b;
    sign_i  = s;
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  // Wait for ready_o and compare; optionally pulse a request at cycle inj_n
  task automatic wait_result(input string tag, input logic [11:0] b, input logic s,
                             input int inj_n, input logic [11:0] inj_bcd);
    logic [7:0] er;
    logic       eo, ee;
    int         elat, n, busy_cnt;
    bit         got;
    ref_model(b, s, er, eo, ee, elat);
    n = 0;
    busy_cnt = 0;
    got = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      if (ready_o) begin
        got = 1'b1;
        break;
      end
      busy_cnt += int'(busy_o);
      if (n == inj_n) begin
        valid_i = 1'b1;
        bcd_i   = inj_bcd;
        sign_i  = 1'b0;
      end else begin
        valid_i = 1'b0;
        bcd_i   = 12'($urandom);
        sign_i  = 1'($urandom);
      end
      n++;
    end
    valid_i = 1'b0;
    if (!got) begin
      check({tag, "_timeout"}, 32'(0), 32'(1));
    end else begin
      check({tag, "_lat"},  32'(n),          32'(elat));
      check({tag, "_busy"}, 32'(busy_cnt),   32'(elat));
      check({tag, "_bz"},   32'(busy_o),     32'(0));
      check({tag, "_res"},  32'(result_o),   32'(er));
      check({tag, "_ovf"},  32'(overflow_o), 32'(eo));
      check({tag, "_err"},  32'(error_o),    32'(ee));
    end
  endtask

  typedef struct {
    logic [11:0] b;
    logic        s;
  } req_t;

  initial begin
    req_t dir[7];
    bit   seen;
    dir[0] = '{12'h127, 1'b0};
    dir[1] = '{12'h128, 1'b1};
    dir[2] = '{12'h045, 1'b1};
    dir[3] = '{12'h200, 1'b0};
    dir[4] = '{12'h999, 1'b1};
    dir[5] = '{12'h1A3, 1'b0};
    dir[6] = '{12'h000, 1'b1};

    reset   = 1'b0;
    valid_i = 1'b0;
    bcd_i   = '0;
    sign_i  = 1'b0;
    #2;
    check("rst_busy",  32'(busy_o),     32'(0));
    check("rst_ready", 32'(ready_o),    32'(0));
    check("rst_res",   32'(result_o),   32'(0));
    check("rst_ovf",   32'(overflow_o), 32'(0));
    check("rst_err",   32'(error_o),    32'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    foreach (dir[i]) begin
      start(dir[i].b, dir[i].s);
      wait_result($sformatf("dir%0d", i), dir[i].b, dir[i].s, -1, 12'h000);
      @(negedge clk);
      check($sformatf("dir%0d_pulse", i), 32'(ready_o), 32'(0));
    end

    // Request during a conversion is ignored; one in the ready cycle is taken
    start(12'h100, 1'b0);
    wait_result("ignore", 12'h100, 1'b0, 3, 12'h050);
    start(12'h050, 1'b0);
    wait_result("b2b", 12'h050, 1'b0, -1, 12'h000);
    @(negedge clk);

    // Asynchronous reset mid-conversion
    start(12'h999, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("arst_busy",  32'(busy_o),     32'(0));
    check("arst_ready", 32'(ready_o),    32'(0));
    check("arst_res",   32'(result_o),   32'(0));
    check("arst_ovf",   32'(overflow_o), 32'(0));
    check("arst_err",   32'(error_o),    32'(0));
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (ready_o || busy_o) seen = 1'b1;
    end
    check("arst_noready", 32'(seen), 32'(0));
    start(12'h099, 1'b0);
    wait_result("post_rst", 12'h099, 1'b0, -1, 12'h000);

    // Randomized requests, mostly legal digits, some with illegal ones
    for (int i = 0; i < 60; i++) begin
      logic [11:0] b;
      logic        s;
      int          gap;
      if ($urandom_range(0, 3) != 0) begin
        b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        if ($urandom_range(0, 3) == 0) b[11:8] = 4'($urandom_range(0, 1));
      end else begin
        b = 12'($urandom);
      end
      s = 1'($urandom);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        @(negedge clk);
        check($sformatf("rnd%0d_pulse", i), 32'(ready_o), 32'(0));
        repeat (gap - 1) @(negedge clk);
      end
      start(b, s);
      wait_result($sformatf("rnd%0d", i), b, s, -1, 12'h000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_to_signed.md
Name: bcd_to_signed

Overview:
- Sequential decoder that turns a keypad-entered decimal magnitude (packed BCD digits) plus a sign flag into an OUT_W-bit two's-complement operand for the signed multiplier.
- It is the inverse of the display-side binary-to-BCD encoder. Conversion uses reverse double-dabble: one shift-right and per-digit correction per clock.
- It sits between the keypad entry control and the multiplier operand inputs. It flags out-of-range values and non-decimal digits.

Parameters:
- DIGITS, 3, number of BCD digits accepted (magnitude range 0..10^DIGITS-1).
- OUT_W, 8, width of the two's-complement result.
- ITER (localparam), ceil(log2(10^DIGITS)) = 10, number of conversion iterations and the width of the internal binary magnitude.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- valid_i  in  1  start request; sampled only in IDLE
- bcd_i  in  4*DIGITS  packed BCD magnitude, most significant digit in the top nibble
- sign_i  in  1  1 = negative
- busy_o  out  1  high while a conversion is in progress
- ready_o  out  1  one-cycle pulse; result, overflow and error are valid in this cycle
- result_o  out  OUT_W  two's-complement result; held until the next ready_o
- overflow_o  out  1  magnitude out of range, result saturated
- error_o  out  1  some input digit is greater than 9

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy_o=0, ready_o=0, result_o=0, overflow_o=0, error_o=0; internal registers cleared. A reset during CONVERT aborts the conversion and produces no ready_o pulse.
- State IDLE: when valid_i=1 at edge k:
  - latch bcd_i and sign_i; clear the binary register and the iteration counter; set busy_o=1.
  - if any latched digit is greater than 9, go to FINISH with the error flag set; otherwise go to CONVERT.
- State CONVERT: one iteration per edge (k+1..k+ITER).
  - Shift the {bcd, bin} register right by 1.
  - Then correct every BCD digit: if the digit is 8 or more, subtract 3.
  - After iteration ITER (edge k+ITER), go to FINISH. The BCD field is 0 at that point.
- State FINISH (edge k+ITER+1 normally, k+1 on error): register the outputs, pulse ready_o for the following cycle, set busy_o=0, go to IDLE.
- Total latency for a valid conversion: valid accepted at edge k, ready_o high in the cycle after edge k+11 (DIGITS=3).
- Range rules, with M = binary magnitude:
  - sign=0: if M > 2^(OUT_W-1)-1 (127), result = 0x7F and overflow_o=1; otherwise result = M.
  - sign=1: if M > 2^(OUT_W-1) (128), result = 0x80 and overflow_o=1; otherwise result = -M truncated to OUT_W bits.
  - Negative zero (sign=1, M=0) gives 0x00 with no overflow.
  - Error case: result_o=0x00, overflow_o=0, error_o=1.
- overflow_o and error_o are held with result_o until the next FINISH.
- valid_i is ignored while busy_o=1 and during FINISH. A request asserted in the cycle ready_o is high is accepted at the next edge (back-to-back requests allowed).
- Inputs are not required to be stable after acceptance, because they are latched.

Decomposition:
- Shared package (bcd_pkg):
  - state enum {IDLE, CONVERT, FINISH}
  - localparams BCD_DIGIT_MAX=9 and CORR_THRESH=8
  - function calculating ITER from DIGITS
- One combinational sub-module, bcd_sub3: 4-bit in, 4-bit out, subtracts 3 when the input is 8 or more. Instantiated DIGITS times via generate.

Test Plan:
- sign=0, bcd=0x127 -> ready_o in the cycle after edge k+11; result=0x7F, overflow=0, error=0; busy_o high for 11 cycles.
- sign=1, bcd=0x128 -> result=0x80, overflow=0. sign=1, bcd=0x045 -> result=0xD3.
- sign=0, bcd=0x200 -> result=0x7F, overflow=1. sign=1, bcd=0x999 -> result=0x80, overflow=1.
- bcd=0x1A3 -> ready_o in the cycle after edge k+1; error=1, result=0x00. Then sign=1, bcd=0x000 -> result=0x00, no flags.
- Start 0x100; pulse valid_i with 0x050 at cycle k+4 -> ignored, result=0x64. Assert valid_i with 0x050 in the ready_o cycle -> accepted, giving 0x32 eleven cycles later.
- Drive reset low at cycle k+5 of a conversion -> all outputs 0 immediately, no ready_o. After release, a new 0x099 conversion gives 0x63.
